// File: rtl/igniter_stepper.sv
// Position stepper: signed jumps that wrap or saturate within 0..POS_MAX,
// followed by an optional cooldown during which new jumps are dropped.
module igniter_stepper #(
  parameter int POS_W       = 3,
  parameter int DELTA_W     = 4,
  parameter int POS_MAX     = 7,
  parameter int HOLD_CYCLES = 2,
  parameter int RESET_POS   = 0
) (
  input  logic               sys_clk,
  input  logic               clr_n,
  input  logic [DELTA_W-1:0] delta,
  input  logic               enable_jump,
  input  logic               sat_mode,
  input  logic               load,
  input  logic [POS_W-1:0]   load_pos,
  output logic               ready,
  output logic [POS_W-1:0]   position,
  output logic               wrapped,
  output logic               clipped
);

  localparam int SW    = ((POS_W > DELTA_W) ? POS_W : DELTA_W) + 2;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic signed [SW-1:0] MAX_S     = SW'(POS_MAX);
  localparam logic signed [SW-1:0] MOD_S     = SW'(POS_MAX + 1);
  localparam logic [POS_W-1:0]     MAX_P     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]     RST_P     = POS_W'(RESET_POS);
  localparam logic [CNT_W-1:0]     HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [POS_W-1:0]  pos_q;
  logic              ready_q;
  logic              wrap_q;
  logic              clip_q;

  logic signed [SW-1:0] sum;
  logic [POS_W-1:0]     jump_pos_d;
  logic [POS_W-1:0]     load_pos_d;
  logic                 jump_wrap_d;
  logic                 jump_clip_d;
  logic                 accept;

  // Sum is wide enough that neither overflow nor underflow is lost before the range checks.
  always_comb begin
    sum         = $signed({{(SW-POS_W){1'b0}}, pos_q})
                + $signed({{(SW-DELTA_W){delta[DELTA_W-1]}}, delta});
    jump_pos_d  = POS_W'(sum);
    jump_wrap_d = 1'b0;
    jump_clip_d = 1'b0;
    if (sum > MAX_S) begin
      if (sat_mode) begin
        jump_pos_d  = MAX_P;
        jump_clip_d = 1'b1;
      end else begin
        jump_pos_d  = POS_W'(sum - MOD_S);
        jump_wrap_d = 1'b1;
      end
    end else if (sum[SW-1]) begin
      if (sat_mode) begin
        jump_pos_d  = '0;
        jump_clip_d = 1'b1;
      end else begin
        jump_pos_d  = POS_W'(sum + MOD_S);
        jump_wrap_d = 1'b1;
      end
    end
    load_pos_d = (load_pos > MAX_P) ? MAX_P : load_pos;
    accept     = enable_jump && ready_q && !load;
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= RST_P;
      ready_q <= 1'b1;
      wrap_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      clip_q <= 1'b0;
      if (load) begin
        pos_q   <= load_pos_d;
        state_q <= IDLE;
        ready_q <= 1'b1;
        cnt_q   <= '0;
      end else if (accept) begin
        pos_q  <= jump_pos_d;
        wrap_q <= jump_wrap_d;
        clip_q <= jump_clip_d;
        if (HOLD_CYCLES > 0) begin
          state_q <= HOLD;
          ready_q <= 1'b0;
          cnt_q   <= HOLD_INIT;
        end
      end else if (state_q == HOLD) begin
        // cnt_q counts the HOLD cycles still to go after the current one.
        if (cnt_q == '0) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign ready    = ready_q;
  assign position = pos_q;
  assign wrapped  = wrap_q;
  assign clipped  = clip_q;

endmodule

// File: doc/igniter_stepper.md
IGNITER_STEPPER -- requirements
Module: igniter_stepper

Interface
REQ-001 Parameter POS_W, default 3, width of the position register.
REQ-002 Parameter DELTA_W, default 4, width of the signed two's-complement jump delta.
REQ-003 Parameter POS_MAX, default 7, highest legal position; POS_MAX SHALL be <= 2^POS_W-1.
REQ-004 Parameter HOLD_CYCLES, default 2, cooldown cycles after an accepted jump; 0 disables cooldown.
REQ-005 Parameter RESET_POS, default 0, position after reset; RESET_POS SHALL be <= POS_MAX.
REQ-006 Parameter constraint: 2^(DELTA_W-1) SHALL be <= POS_MAX+1, so one wrap correction suffices.
REQ-007 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-008 clr_n  in  1  reset, asynchronous, active-low.
REQ-009 delta  in  DELTA_W  signed jump amount.
REQ-010 enable_jump  in  1  jump request, sampled each edge.
REQ-011 sat_mode  in  1  0 = wrap modulo POS_MAX+1; 1 = saturate at 0 and POS_MAX.
REQ-012 load  in  1  synchronous position load request.
REQ-013 load_pos  in  POS_W  value to load.
REQ-014 ready  out  1  high when a jump can be accepted.
REQ-015 position  out  POS_W  current position, registered.
REQ-016 wrapped  out  1  one-cycle pulse: the last jump wrapped.
REQ-017 clipped  out  1  one-cycle pulse: the last jump was clamped.

Function
REQ-018 States: IDLE (ready=1) and HOLD (ready=0); ready SHALL be a registered state decode.
REQ-019 A jump SHALL be accepted on an edge where enable_jump=1, ready=1 and load=0.
REQ-020 Sum = position + sign-extended delta, computed at width max(POS_W,DELTA_W)+2 signed, with no truncation before range checks.
REQ-021 sat_mode=0: sum > POS_MAX -> position = sum-(POS_MAX+1); sum < 0 -> position = sum+(POS_MAX+1); in both cases wrapped=1 for one cycle.
REQ-022 sat_mode=1: sum > POS_MAX -> POS_MAX; sum < 0 -> 0; in both cases clipped=1 for one cycle; exact landing on 0 or POS_MAX is not a clip.
REQ-023 In-range sum -> position = sum; no pulse.
REQ-024 The new position and any pulse SHALL appear together at the edge that accepts the jump; latency is 1 edge from request to output.
REQ-025 delta=0 SHALL be accepted as a normal jump: position unchanged, no pulse, cooldown applies.
REQ-026 When HOLD_CYCLES>0, an accepted jump SHALL enter HOLD for exactly HOLD_CYCLES cycles, then return to IDLE; when HOLD_CYCLES=0, the block SHALL stay in IDLE.
REQ-027 enable_jump while ready=0 SHALL be ignored, not queued.
REQ-028 load=1 SHALL take priority over a jump in any state: position = min(load_pos, POS_MAX), state -> IDLE, hold counter cleared, no pulse.
REQ-029 wrapped and clipped SHALL never be high together, and SHALL be 0 on every edge without an accepted jump.
REQ-030 sat_mode SHALL be sampled only on the accepting edge.

Reset
REQ-031 clr_n=0 SHALL immediately force position=RESET_POS, state=IDLE, ready=1, wrapped=0, clipped=0 and hold counter=0, independent of sys_clk.
REQ-032 Reset asserted mid-HOLD SHALL abort the cooldown; the first edge after release SHALL accept a pending jump.
REQ-033 Inputs SHALL be ignored while clr_n=0.

Verification
REQ-034 Wrap up: position=6, delta=4'b0011, sat_mode=0, jump -> position=1, wrapped pulses 1 cycle, ready low 2 cycles.
REQ-035 Negative: position=1, delta=4'b1101 (-3): sat_mode=0 -> 6 with wrapped; repeated from 1 with sat_mode=1 -> 0 with clipped.
REQ-036 Cooldown: from 0, enable_jump held high, delta=2 -> position 2, 4, 6 on every third edge; ready pattern 0,0,1 after each accepted jump.
REQ-037 Saturate at top: position=7, delta=4'b0111, sat_mode=1 -> 7 with clipped; then delta=0 -> 7 with no pulse.
REQ-038 Load in HOLD: load=1, load_pos=5 on the first HOLD cycle -> position=5 and ready=1 after that edge; load_pos beyond POS_MAX (POS_MAX=5 build) -> 5.
REQ-039 Async reset: clr_n pulsed low between edges during HOLD -> position=RESET_POS and ready=1 before the next edge; a jump with delta=3 on the first edge after release -> position=3.
